pmp_region_checker: RTL and testbench

//  Multi-entry RISC-V PMP checker. Holds NUM_ENTRIES pmpcfg/pmpaddr pairs and resolves one access per request

---
 rtl/pmp_pkg.sv | 17 +
 rtl/pmp_entry_match.sv | 42 ++++
 rtl/pmp_region_checker.sv | 148 ++++++++++++++
 tb/tb_pmp_region_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// pmp_pkg: shared PMP types, encodings and the access-size helper
package pmp_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, TOR = 2'd1, NA4 = 2'd2, NAPOT = 2'd3} pmp_mode_e;
  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_mode_e a;
    logic      x;
    logic      w;
    logic      r;
  } pmp_cfg_t;
  typedef enum logic [1:0] {READ = 2'd0, WRITE = 2'd1, EXEC = 2'd2} pmp_acc_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, RESP = 2'd2} pmp_state_e;
  function automatic logic [2:0] size_span(input logic [1:0] size);
    return size == 2'd0 ? 3'd0 : size == 2'd1 ? 3'd1 : 3'd3;
  endfunction
endpackage

// File: rtl/pmp_entry_match.sv
// pmp_entry_match: combinational span-vs-region match for one PMP entry
//  lo/hi: inclusive access span; mode: entry A field; addr/prev: pmpaddr[i]/pmpaddr[i-1]
//  full_hit: span inside region; partial_hit: span overlaps region without containment
//  PMP_NAPOT_EN: enables NA4/NAPOT regions, otherwise those modes never match
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W+1:0] lo,
  input  logic [ADDR_W+1:0] hi,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] prev,
  output logic              full_hit,
  output logic              partial_hit
);
  logic [ADDR_W+1:0] rlo, rhi, top;
  logic on;
`ifdef PMP_NAPOT_EN
  logic [ADDR_W-1:0] m;
  // m has ones over the trailing-ones run plus the next bit: the NAPOT size mask
  always_comb begin
    m = addr ^ (addr + ADDR_W'(1));
    top = {addr, 2'b00};
    rlo = mode == TOR ? {prev, 2'b00} : mode == NA4 ? {addr, 2'b00} : {addr & ~m, 2'b00};
    rhi = mode == TOR ? top - 1'b1 : mode == NA4 ? {addr, 2'b11} : {addr | m, 2'b11};
    on = mode != OFF && !(mode == TOR && rlo >= top);
    full_hit = on && lo >= rlo && hi <= rhi;
    partial_hit = on && !full_hit && lo <= rhi && hi >= rlo;
  end
`else
  always_comb begin
    top = {addr, 2'b00};
    rlo = {prev, 2'b00};
    rhi = top - 1'b1;
    on = mode == TOR && rlo < top;
    full_hit = on && lo >= rlo && hi <= rhi;
    partial_hit = on && !full_hit && lo <= rhi && hi >= rlo;
  end
`endif
endmodule

// File: rtl/pmp_region_checker.sv
// pmp_region_checker: multi-entry PMP checker scanning ENTRIES_PER_CYCLE entries per cycle
//  cfg_we/addr_we/cfg_idx/cfg_wdata/addr_wdata: entry writes, accepted only while cfg_busy=0
//  req_*: access request (valid/ready); rsp_*: decision (valid/ready), held until accepted
//  PMP_NAPOT_EN: enables NA4/NAPOT matching in pmp_entry_match
module pmp_region_checker
  import pmp_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int ENTRIES_PER_CYCLE = 4,
  parameter int ADDR_W = 32,
  localparam int IW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              addr_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [7:0]        cfg_wdata,
  input  logic [ADDR_W-1:0] addr_wdata,
  output logic              cfg_busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [1:0]        req_type,
  input  logic              req_mmode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_allow,
  output logic              rsp_hit,
  output logic [IW-1:0]     rsp_idx
);
  localparam int EPC = ENTRIES_PER_CYCLE;
  localparam int NG = NUM_ENTRIES / EPC;
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  pmp_state_e state, state_nxt;
  pmp_cfg_t cfg_q [NUM_ENTRIES];
  logic [ADDR_W-1:0] pa_q [NUM_ENTRIES];
  logic [ADDR_W-1:0] a_q;
  logic [1:0] size_q, type_q;
  logic mmode_q, done_q, hit_q, allow_q, bad, last, grp_hit, grp_allow, addr_lock;
  logic [IW-1:0] idx_q, grp_idx, nxt_idx;
  logic [GW-1:0] g;
  logic [ADDR_W:0] span_hi;
  pmp_cfg_t slot_cfg [EPC];
  logic [ADDR_W-1:0] slot_addr [EPC];
  logic [ADDR_W-1:0] slot_prev [EPC];
  logic [EPC-1:0] full, part;
  always_comb begin
    span_hi = {1'b0, a_q} + {{(ADDR_W-2){1'b0}}, size_span(size_q)};
    // reserved encodings and a span wrapping past the top are decided without a scan
    bad = size_q == 2'd3 || type_q == 2'd3 || span_hi[ADDR_W];
    last = g == GW'(NG - 1);
    for (int j = 0; j < EPC; j++) begin
      slot_cfg[j] = cfg_q[int'(g) * EPC + j];
      slot_addr[j] = pa_q[int'(g) * EPC + j];
      slot_prev[j] = int'(g) * EPC + j == 0 ? '0 : pa_q[int'(g) * EPC + j - 1];
    end
    grp_hit = 1'b0;
    grp_allow = 1'b0;
    grp_idx = '0;
    // descending walk so the lowest matching slot is the one left standing
    for (int j = EPC - 1; j >= 0; j--)
      if (full[j] || part[j]) begin
        grp_hit = 1'b1;
        grp_idx = IW'(int'(g) * EPC + j);
        grp_allow = !part[j] && (!(slot_cfg[j].l || !mmode_q) ||
                    (type_q == READ ? slot_cfg[j].r : type_q == WRITE ? slot_cfg[j].w : slot_cfg[j].x));
      end
    nxt_idx = cfg_idx + IW'(1);
    // a locked TOR entry above also freezes this entry's address, its lower bound
    addr_lock = cfg_q[cfg_idx].l ||
                (int'(cfg_idx) < NUM_ENTRIES - 1 && cfg_q[nxt_idx].l && cfg_q[nxt_idx].a == TOR);
  end
  for (genvar s = 0; s < EPC; s++) begin : g_match
    pmp_entry_match #(.ADDR_W(ADDR_W)) u_match (
      .lo({2'b00, a_q}),
      .hi({1'b0, span_hi}),
      .mode(slot_cfg[s].a),
      .addr(slot_addr[s]),
      .prev(slot_prev[s]),
      .full_hit(full[s]),
      .partial_hit(part[s])
    );
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (req_valid ? SCAN : IDLE) :
                state == SCAN ? (bad || done_q ? RESP : SCAN) :
                (rsp_ready ? IDLE : RESP);
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    cfg_busy = state != IDLE;
    rsp_allow = allow_q;
    rsp_hit = hit_q;
    rsp_idx = idx_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg_q[i] <= '0;
        pa_q[i] <= '0;
      end
    end else if (state == IDLE && int'(cfg_idx) < NUM_ENTRIES) begin
      if (cfg_we && !cfg_q[cfg_idx].l) cfg_q[cfg_idx] <= pmp_cfg_t'({cfg_wdata[7], 2'b00, cfg_wdata[4:0]});
      if (addr_we && !addr_lock) pa_q[cfg_idx] <= addr_wdata;
    end
  // a group result is registered and acted on one cycle later, so a hit in group g responds g+2 cycles after accept
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_q <= '0;
      size_q <= '0;
      type_q <= '0;
      mmode_q <= 1'b0;
      g <= '0;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      allow_q <= 1'b0;
      idx_q <= '0;
    end else if (state == IDLE && req_valid) begin
      a_q <= req_addr;
      size_q <= req_size;
      type_q <= req_type;
      mmode_q <= req_mmode;
      g <= '0;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      allow_q <= req_mmode;
      idx_q <= '0;
    end else if (state == SCAN) begin
      if (bad) begin
        hit_q <= 1'b0;
        allow_q <= 1'b0;
        idx_q <= '0;
      end else if (!done_q) begin
        g <= g + GW'(1);
        done_q <= grp_hit || last;
        if (grp_hit) begin
          hit_q <= 1'b1;
          allow_q <= grp_allow;
          idx_q <= grp_idx;
        end
      end
    end
endmodule

// File: tb/tb_pmp_region_checker.sv
// tb_pmp_region_checker: directed table-driven bench for pmp_region_checker
module tb_pmp_region_checker;
  logic clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, addr_we = 1'b0;
  logic [3:0] cfg_idx = '0;
  logic [7:0] cfg_wdata = '0;
  logic [31:0] addr_wdata = '0, req_addr = '0;
  logic cfg_busy, req_valid = 1'b0, req_ready, req_mmode = 1'b0;
  logic [1:0] req_size = '0, req_type = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_allow, rsp_hit;
  logic [3:0] rsp_idx;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    string nm;
    logic [31:0] addr;
    logic [1:0] sz;
    logic [1:0] ty;
    logic m;
    logic al;
    logic hi;
    logic [3:0] ix;
    int lat;
  } vec_t;
  vec_t vt [17];
  pmp_region_checker #(.NUM_ENTRIES(16), .ENTRIES_PER_CYCLE(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .addr_we(addr_we), .cfg_idx(cfg_idx),
    .cfg_wdata(cfg_wdata), .addr_wdata(addr_wdata), .cfg_busy(cfg_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_type(req_type), .req_mmode(req_mmode), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_allow(rsp_allow), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask
  task automatic wr(input int i, input logic ce, input logic [7:0] c, input logic ae, input logic [31:0] a);
    @(negedge clk);
    cfg_idx = 4'(i);
    cfg_we = ce;
    cfg_wdata = c;
    addr_we = ae;
    addr_wdata = a;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    addr_we = 1'b0;
  endtask
  task automatic accept(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty, input logic m);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = a;
    req_size = sz;
    req_type = ty;
    req_mmode = m;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic drain();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask
  task automatic run(input string nm, input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                     input logic m, input logic eal, input logic ehi, input logic [3:0] eix, input int elat);
    int lat;
    accept(a, sz, ty, m);
    wait_rsp(lat);
    chk({nm, "_allow"}, 32'(rsp_allow), 32'(eal));
    chk({nm, "_hit"}, 32'(rsp_hit), 32'(ehi));
    chk({nm, "_idx"}, 32'(rsp_idx), 32'(eix));
    if (elat > 0) chk({nm, "_lat"}, 32'(lat), 32'(elat));
    drain();
  endtask
  initial begin
    int lat;
    logic [3:0] hold_idx;
    vt[0] = '{"t1_rd_u", 32'h0FFC, 2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0, 2};
    vt[1] = '{"t1_wr_u", 32'h0FFC, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 4'd0, 2};
    vt[2] = '{"wr_m_unlocked", 32'h0FFC, 2'd2, 2'd1, 1'b1, 1'b1, 1'b1, 4'd0, 2};
    vt[3] = '{"t2_partial", 32'h1FFE, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 4'd3, 2};
    vt[4] = '{"partial_e0_m", 32'h0FFE, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 2};
    vt[5] = '{"tor_edge", 32'h1000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd1, 2};
    vt[6] = '{"t3_exec_u", 32'h1100, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 4'd1, 2};
    vt[7] = '{"exec_m", 32'h1100, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1, 4'd1, 2};
    vt[8] = '{"grp2_rd", 32'h4000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd9, 4};
    vt[9] = '{"grp2_wr", 32'h4000, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 4'd9, 4};
    vt[10] = '{"nohit_u", 32'h8000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 5};
    vt[11] = '{"nohit_m", 32'h8000, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 5};
    vt[12] = '{"rsv_size", 32'h0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1};
    vt[13] = '{"rsv_type", 32'h0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 4'd0, 1};
    vt[14] = '{"wrap", 32'hFFFF_FFFE, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1};
    vt[15] = '{"top_half", 32'hFFFF_FFFE, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 5};
    vt[16] = '{"e3_full", 32'h1900, 2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 4'd3, 2};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_allow", 32'(rsp_allow), 32'd0);
    chk("rst_hit", 32'(rsp_hit), 32'd0);
    chk("rst_idx", 32'(rsp_idx), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    rst_n = 1'b1;
    wr(0, 1'b1, 8'h09, 1'b1, 32'h400);
    wr(1, 1'b1, 8'h0B, 1'b1, 32'h600);
    wr(2, 1'b0, 8'h00, 1'b1, 32'h400);
    wr(3, 1'b1, 8'h0F, 1'b1, 32'h800);
    wr(5, 1'b0, 8'h00, 1'b1, 32'h400);
    wr(6, 1'b1, 8'h0F, 1'b1, 32'h600);
    wr(8, 1'b0, 8'h00, 1'b1, 32'h1000);
    wr(9, 1'b1, 8'h09, 1'b1, 32'h1100);
    foreach (vt[i]) run(vt[i].nm, vt[i].addr, vt[i].sz, vt[i].ty, vt[i].m, vt[i].al, vt[i].hi, vt[i].ix, vt[i].lat);
    wr(2, 1'b0, 8'h00, 1'b1, 32'h700);
    wr(2, 1'b1, 8'h89, 1'b0, 32'h0);
    wr(1, 1'b0, 8'h00, 1'b1, 32'h123);
    wr(2, 1'b1, 8'h0F, 1'b1, 32'h7FF);
    run("lock_pa1_kept", 32'h1700, 2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 4'd1, 2);
    run("lock_m_wr", 32'h1900, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 4'd2, 2);
    run("lock_pa2_kept", 32'h1C00, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 4'd3, 2);
    accept(32'h1700, 2'd2, 2'd0, 1'b0);
    chk("busy_in_scan", 32'(cfg_busy), 32'd1);
    wait_rsp(lat);
    chk("hold_lat", 32'(lat), 32'd2);
    hold_idx = rsp_idx;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cfg_idx = 4'd0;
      cfg_wdata = 8'h0F;
      cfg_we = c == 2;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_idx", 32'(rsp_idx), 32'(hold_idx));
      chk("hold_allow", 32'(rsp_allow), 32'd1);
      chk("hold_hit", 32'(rsp_hit), 32'd1);
    end
    cfg_we = 1'b0;
    drain();
    chk("after_drain_ready", 32'(req_ready), 32'd1);
    run("busy_write_dropped", 32'h0FFC, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 4'd0, 2);
    accept(32'h8000, 2'd2, 2'd0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_busy", 32'(cfg_busy), 32'd0);
    chk("midrst_allow", 32'(rsp_allow), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("midrst_dropped", 32'(rsp_valid), 32'd0);
    run("cleared_e0", 32'h0FFC, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 5);
    run("cleared_lock", 32'h1900, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0, 4'd0, 5);
    wr(0, 1'b1, 8'h19, 1'b1, 32'h1FF);
`ifdef PMP_NAPOT_EN
    run("napot_u", 32'h0FFF, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0, 2);
    run("napot_m", 32'h0FFF, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 4'd0, 2);
    run("napot_out", 32'h1000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 5);
`else
    run("napot_off_u", 32'h0FFF, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 5);
    run("napot_off_m", 32'h0FFF, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 5);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
